// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder (one full-adder cell plus a carry flop).
// Operands are loaded on an accepted start and consumed LSB first, one bit-pair
// per clock. After WIDTH cycles, {c_out, sum} = a + b + c_in is captured and held.
// Legal WIDTH range is 2..32.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the ovf output. ovf is the
// two's-complement overflow flag, captured and held together with sum.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-2:0] sum_sr_q, sum_sr_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             c_out_q, c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic             s_bit;
   logic             carry_nxt;
   logic [WIDTH-1:0] sum_cat;

   // Full-adder cell on the current LSBs; sum_cat is the sum register after this bit shifts in.
   always_comb begin
      s_bit     = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
      carry_nxt = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
      sum_cat   = {s_bit, sum_sr_q};
   end

   // Next-state logic: load on accepted start, shift one bit per RUN cycle, capture on the last bit.
   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      c_out_d  = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d  = S_RUN;
               a_sr_d   = a;
               b_sr_d   = b;
               carry_d  = c_in;
               cnt_d    = '0;
               sum_sr_d = '0;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_RUN: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            sum_sr_d = sum_cat[WIDTH-1:1];
            carry_d  = carry_nxt;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               sum_d   = sum_cat;
               c_out_d = carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = carry_q ^ carry_nxt;
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any addition in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         c_out_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         c_out_q  <= c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy  = (state_q == S_RUN);
   assign done  = (state_q == S_DONE);
   assign sum   = sum_q;
   assign c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder (WIDTH=8).
// A cycle-level reference model tracks each addition from acceptance to its done
// cycle and computes results with plain integer arithmetic.
module tb_serial_adder;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             c_out;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;
`endif

   int test_count = 0;
   int fail_count = 0;

   // model state: 0 idle, 1..WIDTH running, WIDTH+1 done cycle
   int         phase = 0;
   int         completions = 0;
   logic [8:0] pend_res = '0;
   logic [8:0] held_res = '0;
   logic       pend_ovf = 1'b0;
   logic       held_ovf = 1'b0;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .c_out (c_out)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      test_count++;
      if (got !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] refSum(input logic [7:0] x, input logic [7:0] y, input logic ci);
      int t;
      t = int'(x) + int'(y) + int'(ci);
      return t[8:0];
   endfunction

   function automatic logic refOvf(input logic [7:0] x, input logic [7:0] y, input logic ci);
      int t;
      t = int'(signed'(x)) + int'(signed'(y)) + int'(ci);
      return (t > 127) || (t < -128);
   endfunction

   // Reference model and per-cycle scoreboard, sampled away from the active edge
   always @(negedge clk) begin
      if (rst) begin
         checkOutput("rst_busy", 32'(busy), 32'(0));
         checkOutput("rst_done", 32'(done), 32'(0));
         checkOutput("rst_sum", 32'(sum), 32'(0));
         checkOutput("rst_cout", 32'(c_out), 32'(0));
`ifdef SERIAL_ADDER_OVF_EN
         checkOutput("rst_ovf", 32'(ovf), 32'(0));
`endif
         phase    = 0;
         held_res = '0;
         held_ovf = 1'b0;
      end else begin
         checkOutput("busy", 32'(busy), 32'(phase >= 1 && phase <= WIDTH));
         checkOutput("done", 32'(done), 32'(phase == WIDTH + 1));
         checkOutput("sum", 32'(sum), 32'(held_res[7:0]));
         checkOutput("c_out", 32'(c_out), 32'(held_res[8]));
`ifdef SERIAL_ADDER_OVF_EN
         checkOutput("ovf", 32'(ovf), 32'(held_ovf));
`endif
         if (phase == WIDTH + 1) completions++;
         if ((phase == 0 || phase == WIDTH + 1) && start === 1'b1) begin
            pend_res = refSum(a, b, c_in);
            pend_ovf = refOvf(a, b, c_in);
            phase    = 1;
         end else if (phase >= 1 && phase < WIDTH) begin
            phase = phase + 1;
         end else if (phase == WIDTH) begin
            phase    = WIDTH + 1;
            held_res = pend_res;
            held_ovf = pend_ovf;
         end else begin
            phase = 0;
         end
      end
   end

   // One addition from idle: start for one cycle, then check the done cycle against constants
   task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                                input logic [7:0] esum, input logic ecout, input string tag);
      @(posedge clk); #1;
      start = 1'b1; a = ia; b = ib; c_in = icin;
      @(posedge clk); #1;
      start = 1'b0; a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
      repeat (WIDTH) @(posedge clk);
      #1;
      checkOutput({tag, "_done"}, 32'(done), 32'(1));
      checkOutput({tag, "_sum"}, 32'(sum), 32'(esum));
      checkOutput({tag, "_cout"}, 32'(c_out), 32'(ecout));
      @(posedge clk); #1;
   endtask

   initial begin
      int c0;
      int cyc;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // directed additions, including carry-out boundaries
      applyStimulus(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "t1");
      applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "t2a");
      applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "t2b");

      // start pulsed mid-RUN must be ignored
      @(posedge clk); #1;
      start = 1'b1; a = 8'h5A; b = 8'h3C; c_in = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1; a = 8'hFF; b = 8'hFF; c_in = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("t3_done", 32'(done), 32'(1));
      checkOutput("t3_sum", 32'(sum), 32'(8'h96));
      @(posedge clk); #1;
      checkOutput("t3_single_done", 32'(done), 32'(0));
      repeat (10) @(posedge clk);

      // reset in the fourth RUN cycle aborts immediately
      #1;
      start = 1'b1; a = 8'h11; b = 8'h22; c_in = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("t4_pre_busy", 32'(busy), 32'(1));
      rst = 1'b1;
      #1;
      checkOutput("t4_busy", 32'(busy), 32'(0));
      checkOutput("t4_done", 32'(done), 32'(0));
      checkOutput("t4_sum", 32'(sum), 32'(0));
      checkOutput("t4_cout", 32'(c_out), 32'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      applyStimulus(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "t4b");

      // start held high: three back-to-back additions
      c0 = completions;
      @(posedge clk); #1;
      start = 1'b1; a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
      for (int i = 0; i < 3 * (WIDTH + 1); i++) begin
         @(posedge clk); #1;
         a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
      end
      start = 1'b0;
      @(negedge clk); #1;
      checkOutput("t5_dones", 32'(completions - c0), 32'(3));

`ifdef SERIAL_ADDER_OVF_EN
      applyStimulus(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "t6a");
      checkOutput("t6a_ovf", 32'(ovf), 32'(1));
      applyStimulus(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "t6b");
      checkOutput("t6b_ovf", 32'(ovf), 32'(1));
      applyStimulus(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "t6c");
      checkOutput("t6c_ovf", 32'(ovf), 32'(0));
`endif

      // random traffic: 200 additions, each done checked by the model
      c0 = completions;
      cyc = 0;
      while ((completions - c0) < 200 && cyc < 6000) begin
         @(posedge clk); #1;
         start = ($urandom_range(0, 3) != 0);
         a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
         cyc++;
      end
      start = 1'b0;
      checkOutput("rand_count", 32'((completions - c0) >= 200), 32'(1));

      repeat (WIDTH + 3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
